// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard unit for a five-stage in-order pipeline. It generates operand
//   forwarding selects, load-use and branch stall/flush controls, and
//   memory-wait stalls with a timeout fault.
//
// Parameters
//   TIMEOUT      memory-wait cycles tolerated before faulting (1..255)
//
// Ports
//   clk, reset             single clock, synchronous active-high reset
//   Rs1D, Rs2D             source registers of the instruction in D
//   Rs1E, Rs2E, RdE        sources and destination of the instruction in E
//   ResultSrcE0            the instruction in E is a load
//   PCSrcE                 taken branch/jump resolved in E
//   RdM, RegWriteM         writeback target/enable of the instruction in M
//   RdW, RegWriteW         writeback target/enable of the instruction in W
//   MemReqM, MemReadyM     data-memory request in M, memory ready
//   StallF/D/E/M           hold PC, IF/ID, ID/EX, EX/MEM registers
//   FlushD/E/W             bubble IF/ID, ID/EX, MEM/WB registers
//   ForwardAE, ForwardBE   ALU operand select (00 RF, 10 from M, 01 from W)
//   MemErr                 sticky memory-timeout fault
//   StallCount             saturating count of cycles with StallF set
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteW,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemErr,
  output logic [15:0] StallCount
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  localparam logic [8:0] TIMEOUT_CNT = 9'(TIMEOUT);

  state_e      state_q, state_d;
  logic [8:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic        lw_stall;
  logic        mem_stall;
  logic        hold_all;

  // M has priority over W because it carries the younger result.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m,
                                         input logic       we_m,
                                         input logic [4:0] rd_w,
                                         input logic       we_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  // The ready cycle itself is not a stall, so the pipe advances on that edge.
  assign mem_stall = MemReqM && !MemReadyM;
  assign hold_all  = mem_stall || (state_q == S_ERR);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= 9'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          state_d    = S_WAIT;
          wait_cnt_d = 9'd1;
        end
      end
      S_WAIT: begin
        if (!mem_stall) begin
          state_d    = S_RUN;
          wait_cnt_d = 9'd0;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          state_d = S_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 9'd1;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = 9'd0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      if (hold_all) begin
        // E is frozen, so a branch resolved there waits until release.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        // Squashing D also removes any load-use dependency it had.
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallF && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  assign MemErr     = (state_q == S_ERR);
  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl (TIMEOUT=4). Each stimulus cycle
//   pushes its hand-computed expected outputs into a queue; a monitor on the
//   falling edge pops and compares against the DUT outputs.
//   Expected word: {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW,
//                   ForwardAE, ForwardBE, MemErr, StallCount}
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCount;

  logic [27:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemErr(MemErr), .StallCount(StallCount)
  );

  function automatic logic [27:0] ex(input logic [3:0] st, input logic [2:0] fl,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic me, input logic [15:0] c);
    return {st, fl, fa, fb, me, c};
  endfunction

  // Monitor: one popped expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [27:0] e;
      logic [27:0] a;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
            ForwardAE, ForwardBE, MemErr, StallCount};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got stall=%b flush=%b fa=%b fb=%b err=%b cnt=%0d, expected stall=%b flush=%b fa=%b fb=%b err=%b cnt=%0d",
                 nm, a[27:24], a[23:21], a[20:19], a[18:17], a[16], a[15:0],
                 e[27:24], e[23:21], e[20:19], e[18:17], e[16], e[15:0]);
      end
    end
  end

  task automatic clr();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  // Push expectation for the inputs currently applied, then advance a cycle.
  task automatic chk(input string nm, input logic [27:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    // Forwarding and memory-stall conditions present during reset must be masked.
    Rs1E = 5; RdM = 5; RegWriteM = 1; MemReqM = 1;
    @(posedge clk); #1;
    chk("reset_outputs", ex(4'b0000, 3'b111, 2'b00, 2'b00, 1'b0, 16'd0));

    reset = 1'b0;
    clr();
    Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    chk("fwdA_M_prio", ex(4'b0000, 3'b000, 2'b10, 2'b00, 1'b0, 16'd0));
    RdM = 0;
    chk("fwdA_W_rdm0", ex(4'b0000, 3'b000, 2'b01, 2'b00, 1'b0, 16'd0));
    RdW = 0;
    chk("fwdA_none_rdw0", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 16'd0));
    clr();
    Rs1E = 3; Rs2E = 9; RdM = 9; RegWriteM = 1; RdW = 9; RegWriteW = 1;
    chk("fwdB_M", ex(4'b0000, 3'b000, 2'b00, 2'b10, 1'b0, 16'd0));
    RegWriteM = 0;
    chk("fwdB_W", ex(4'b0000, 3'b000, 2'b00, 2'b01, 1'b0, 16'd0));
    RegWriteW = 0;
    chk("fwdB_no_we", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 16'd0));

    // Load-use: one bubble, then load sits in M and forwards to Rs2E.
    clr();
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    chk("loaduse_bubble", ex(4'b1100, 3'b010, 2'b00, 2'b00, 1'b0, 16'd0));
    clr();
    Rs2E = 7; RdM = 7; RegWriteM = 1;
    chk("loaduse_after", ex(4'b0000, 3'b000, 2'b00, 2'b10, 1'b0, 16'd1));
    clr();
    ResultSrcE0 = 1; RdE = 0; Rs1D = 0;
    chk("load_x0_nostall", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 16'd1));

    // Branch wins over load-use.
    clr();
    PCSrcE = 1; ResultSrcE0 = 1; RdE = 7; Rs1D = 7;
    chk("branch_over_lw", ex(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 16'd1));

    // Memory wait of 3 cycles with a branch held in E.
    clr();
    MemReqM = 1; PCSrcE = 1;
    chk("memwait_1", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 16'd1));
    chk("memwait_2", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 16'd2));
    chk("memwait_3", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 16'd3));
    MemReadyM = 1;
    chk("memwait_release_branch", ex(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 16'd4));
    clr();
    chk("memwait_run", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 16'd4));

    // Timeout: TIMEOUT=4 faults on the 5th wait edge.
    MemReqM = 1;
    chk("tmo_w1", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 16'd4));
    chk("tmo_w2", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 16'd5));
    chk("tmo_w3", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 16'd6));
    chk("tmo_w4", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 16'd7));
    chk("tmo_w5", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 16'd8));
    chk("tmo_err", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 16'd9));
    MemReadyM = 1;
    chk("err_sticky_ready", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 16'd10));
    clr();
    PCSrcE = 1;
    chk("err_holds_branch", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 16'd11));

    // Reset out of ERR while a request is still pending.
    clr();
    reset = 1'b1; MemReqM = 1;
    chk("reset_in_err", ex(4'b0000, 3'b111, 2'b00, 2'b00, 1'b1, 16'd12));
    reset = 1'b0;
    chk("after_reset_wait", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 16'd0));
    clr();
    chk("after_reset_run", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 16'd1));

    // Reset mid-WAIT returns to RUN in one edge.
    MemReqM = 1;
    chk("wait_again", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 16'd1));
    reset = 1'b1;
    chk("reset_mid_wait", ex(4'b0000, 3'b111, 2'b00, 2'b00, 1'b0, 16'd2));
    reset = 1'b0;
    clr();
    chk("run_after_wait_reset", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 16'd0));

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: memory-wait cycles before fault, range 1..255.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Rs1D, Rs2D  in  5 each  source register numbers of the instruction in D.
REQ-005 Rs1E, Rs2E, RdE  in  5 each  sources and destination of the instruction in E.
REQ-006 ResultSrcE0  in  1  instruction in E is a load.
REQ-007 PCSrcE  in  1  taken branch/jump resolved in E.
REQ-008 RdM, RegWriteM / RdW, RegWriteW  in  5+1 each  writeback targets and enables in M and W.
REQ-009 MemReqM, MemReadyM  in  1 each  data-memory request in M; memory ready.
REQ-010 StallF, StallD, StallE, StallM  out  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-011 FlushD, FlushE, FlushW  out  1 each  clear IF/ID, ID/EX and MEM/WB to zero (bubble).
REQ-012 ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 register file, 10 from M, 01 from W.
REQ-013 MemErr  out  1  sticky memory-timeout fault.
REQ-014 StallCount  out  16  saturating count of cycles with StallF=1.

Function
REQ-015 Forwarding (combinational) SHALL be: ForwardAE=10 if RegWriteM and RdM!=0 and RdM==Rs1E; else 01 if RegWriteW and RdW!=0 and RdW==Rs1E; else 00. ForwardBE is identical using Rs2E. M has priority over W.
REQ-016 lwStall SHALL be ResultSrcE0 and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
REQ-017 memStall SHALL be MemReqM and not MemReadyM.
REQ-018 FSM states SHALL be RUN, WAIT and ERR, encoded in 2 bits. A 9-bit wait counter (waitCnt) SHALL track memory-wait cycles.
REQ-019 RUN: if memStall, go to WAIT with waitCnt=1; else stay in RUN.
REQ-020 WAIT: if not memStall, go to RUN with waitCnt=0. Else, if waitCnt==TIMEOUT, go to ERR. Else increment waitCnt.
REQ-021 ERR: stay in ERR until reset. MemErr=1 in ERR.
REQ-022 Priority SHALL be memStall or ERR, then PCSrcE, then lwStall.
REQ-023 memStall or ERR: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. A concurrent PCSrcE is not acted on, because E is held; it is re-evaluated after release.
REQ-024 PCSrcE (no memStall): FlushD=FlushE=1, all stalls 0. This also suppresses lwStall, since the D instruction is squashed.
REQ-025 lwStall only: StallF=StallD=1, FlushE=1. Exactly one bubble per load-use pair: the next cycle, the load is in M and lwStall is false.
REQ-026 Otherwise all stalls and flushes SHALL be 0.
REQ-027 The release cycle (MemReadyM=1) SHALL have memStall=0: the pipeline advances in that same edge.
REQ-028 StallCount SHALL increment on each edge where StallF=1 and saturate at 16'hFFFF.
REQ-029 All stall, flush and forward outputs are combinational from inputs and state. There is no added latency.

Reset
REQ-030 While reset=1: state=RUN, waitCnt=0, MemErr=0 and StallCount=0 at the next edge.
REQ-031 While reset=1, combinationally: stalls=0, FlushD=FlushE=FlushW=1, ForwardAE=ForwardBE=00.
REQ-032 Reset asserted mid-WAIT or in ERR SHALL return the block to RUN in one edge, regardless of MemReqM.

Verification
REQ-033 Forwarding:
- Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10.
- RdM=0 -> ForwardAE=01.
- RdW=0 as well -> ForwardAE=00.
REQ-034 Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> one cycle of StallF=StallD=FlushE=1, then all 0; StallCount=1.
REQ-035 Branch plus load-use: PCSrcE=1 and lwStall in the same cycle -> FlushD=FlushE=1, StallF=0.
REQ-036 Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> all stalls and FlushW=1 for exactly 3 cycles; state WAIT then RUN; a branch held in E flushes on the release cycle.
REQ-037 Timeout: TIMEOUT=4, MemReadyM held 0 -> MemErr=1 after the 5th wait edge, stays 1 after MemReadyM=1; reset -> MemErr=0, state RUN.
